// File: rtl/tdc_readout_arbiter_pkg.sv
// tdc_readout_arbiter_pkg: shared FSM state, event record type and sync depth for the TDC readout arbiter
package TDCReadoutPkg;

    localparam int TDC_SYNC_STAGES = 2;
    localparam int TDC_CHAN_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND,
        CLEAR
    } arb_state_t;

    typedef struct packed {
        logic [TDC_CHAN_W-1:0] chan;
        logic [31:0]           timestamp;
        logic [31:0]           tot;
    } tdc_event_t;

endpackage

// File: rtl/tdc_readout_arbiter_if.sv
// tdc_readout_arbiter_if: valid/ready event record stream from the arbiter to the DAQ consumer
interface tdc_readout_arbiter_if #(
    parameter int CHAN_W = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [CHAN_W-1:0] out_chan;
    logic [31:0]       out_timestamp;
    logic [31:0]       out_tot;

    modport master (
        output out_valid,
        output out_chan,
        output out_timestamp,
        output out_tot,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_chan,
        input  out_timestamp,
        input  out_tot,
        output out_ready
    );
endinterface

// File: rtl/tdc_readout_arbiter_sync.sv
// tdc_sync_2ff: multi-bit flag synchronizer, each bit resynchronized independently
module tdc_sync_2ff
    import TDCReadoutPkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [TDC_SYNC_STAGES-1:0][W-1:0] sync_q;

    // shift the asynchronous flags through the synchronizer stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[TDC_SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[TDC_SYNC_STAGES-1];

endmodule

// File: rtl/tdc_readout_arbiter.sv
// tdc_readout_arbiter: grants one flagged TDC channel at a time, streams its record, then clears it (TDC_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority)
module tdc_readout_arbiter
    import TDCReadoutPkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int CHAN_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [N_CHANNELS-1:0]       has_event,
    input  logic [N_CHANNELS-1:0][31:0] timestamp,
    input  logic [N_CHANNELS-1:0][31:0] tot,
    output logic [N_CHANNELS-1:0]       clear,
    output logic                        busy,
    tdc_readout_arbiter_if.master       out_if
);

    arb_state_t            state_q, state_d;
    logic [CHAN_W-1:0]     g_q, g_d;
    logic                  valid_q, valid_d;
    logic [N_CHANNELS-1:0] clear_q, clear_d;
    logic                  busy_q;
    tdc_event_t            evt_q, cap;
    logic [N_CHANNELS-1:0] evt_s;
    logic [N_CHANNELS-1:0] g_oh;
    logic [CHAN_W-1:0]     start;

    // picks the pending channel closest (cyclically) at or after start
    function automatic logic [CHAN_W-1:0] pick(input logic [N_CHANNELS-1:0] req, input logic [CHAN_W-1:0] first);
        logic [CHAN_W-1:0] g;
        int                best;
        int                off;
        g    = '0;
        best = N_CHANNELS;
        for (int i = 0; i < N_CHANNELS; i++) begin
            off = (i - int'(first) + N_CHANNELS) % N_CHANNELS;
            if (req[i] && off < best) begin
                best = off;
                g    = CHAN_W'(i);
            end
        end
        return g;
    endfunction

    tdc_sync_2ff #(.W(N_CHANNELS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (has_event),
        .q_o   (evt_s)
    );

    assign g_oh = N_CHANNELS'(1) << g_q;

`ifdef TDC_ARB_ROUND_ROBIN_EN
    logic [CHAN_W-1:0] ptr_q;

    // pointer holds the next search start, advanced as a grant enters CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= (state_q == SEND && state_d == CLEAR) ? ((g_q == CHAN_W'(N_CHANNELS-1)) ? '0 : g_q + 1'b1) : ptr_q;
    end

    assign start = ptr_q;
`else
    assign start = '0;
`endif

    // mux the granted channel's timestamp and tot into a record
    always_comb begin
        cap = '{chan: TDC_CHAN_W'(g_q), timestamp: 32'h0, tot: 32'h0};
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (g_q == CHAN_W'(i)) begin
                cap.timestamp = timestamp[i];
                cap.tot       = tot[i];
            end
        end
    end

    // next-state and next-output logic; outputs are registered from these
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        valid_d = 1'b0;
        clear_d = '0;
        case (state_q)
            IDLE: begin
                if (enable && |evt_s) begin
                    state_d = CAPTURE;
                    g_d     = pick(evt_s, start);
                end
            end
            CAPTURE: begin
                state_d = SEND;
                valid_d = 1'b1;
            end
            SEND: begin
                state_d = out_if.out_ready ? CLEAR : SEND;
                valid_d = !out_if.out_ready;
                clear_d = out_if.out_ready ? g_oh : '0;
            end
            CLEAR: begin
                state_d = |(evt_s & g_oh) ? CLEAR : IDLE;
                clear_d = |(evt_s & g_oh) ? g_oh : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // state, registered outputs and the record latched in CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            valid_q <= 1'b0;
            clear_q <= '0;
            busy_q  <= 1'b0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            valid_q <= valid_d;
            clear_q <= clear_d;
            busy_q  <= state_d != IDLE;
            evt_q   <= (state_q == CAPTURE) ? cap : evt_q;
        end
    end

    assign clear                = clear_q;
    assign busy                 = busy_q;
    assign out_if.out_valid     = valid_q;
    assign out_if.out_chan      = CHAN_W'(evt_q.chan);
    assign out_if.out_timestamp = evt_q.timestamp;
    assign out_if.out_tot       = evt_q.tot;

endmodule
